// File: rtl/secure_storage_pkg.sv
// Shared types and helpers for the secure storage request path: FSM states,
// response error codes and permission-bit indexing.
package secure_storage_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_RD_DENY = 2'b01,
        ERR_WR_DENY = 2'b10
    } rsp_err_t;

    localparam int DEFAULT_REGIONS = 4;

    // Number of address bits that select a region (0 when there is one region).
    function automatic int region_bits(input int regions);
        return (regions > 1) ? $clog2(regions) : 0;
    endfunction

    // Width of a region index signal; never narrower than one bit.
    function automatic int region_idx_w(input int regions);
        return (regions > 1) ? $clog2(regions) : 1;
    endfunction

    localparam int REGION_IDX_W = region_idx_w(DEFAULT_REGIONS);

    function automatic int perm_rd_bit(input int region);
        return 2 * region;
    endfunction

    function automatic int perm_wr_bit(input int region);
        return 2 * region + 1;
    endfunction

endpackage

// File: rtl/storage_perm_check.sv
// Combinational region permission check; privileged commands always pass.
// Shared between the host initiator and the DMA initiator.
module storage_perm_check
    import secure_storage_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int REGIONS = DEFAULT_REGIONS
) (
    input  logic [2*REGIONS-1:0] perm,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 write,
    input  logic                 priv,
    output logic                 allow
);

    localparam int RW    = region_idx_w(REGIONS);
    localparam int SHIFT = ADDR_W - region_bits(REGIONS);

    logic [RW-1:0]      region;
    logic [REGIONS-1:0] rd_hit;
    logic [REGIONS-1:0] wr_hit;

    // With a single region the shift clears the address and region 0 always matches.
    assign region = RW'(addr >> SHIFT);

    generate
        for (genvar gi = 0; gi < REGIONS; gi++) begin : g_region
            logic sel;
            assign sel        = (region == RW'(gi));
            assign rd_hit[gi] = sel & perm[perm_rd_bit(gi)];
            assign wr_hit[gi] = sel & perm[perm_wr_bit(gi)];
        end
    endgenerate

    assign allow = priv | (write ? (|wr_hit) : (|rd_hit));

endmodule

// File: rtl/storage_access_initiator.sv
// Host-side request front end for the secure storage array: permission-checked,
// one command in flight. Define ACCESS_LOG_EN to add deny_cnt / last_deny_addr.
module storage_access_initiator
    import secure_storage_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int REGIONS = DEFAULT_REGIONS,
    parameter int RD_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic                 req_priv,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic [1:0]           rsp_err,
    input  logic                 cfg_we,
    input  logic [2*REGIONS-1:0] cfg_perm,
    input  logic                 cfg_lock,
    output logic                 perm_locked,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [DATA_W-1:0]    mem_rdata
`ifdef ACCESS_LOG_EN
    ,
    output logic [15:0]          deny_cnt,
    output logic [ADDR_W-1:0]    last_deny_addr
`endif
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t              state_reg;
    logic                req_ready_reg;
    logic                rsp_valid_reg;
    logic [DATA_W-1:0]   rsp_rdata_reg;
    rsp_err_t            rsp_err_reg;
    logic                mem_we_reg;
    logic                mem_re_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic                cmd_write_reg;
    logic                cmd_priv_reg;
    logic [ADDR_W-1:0]   cmd_addr_reg;
    logic [DATA_W-1:0]   cmd_wdata_reg;
    logic [CNT_W-1:0]    wait_cnt_reg;
    logic [2*REGIONS-1:0] perm_reg;
    logic                lock_reg;
    logic                allow;
    rsp_err_t            deny_err_next;

    // Checked against perm_reg as it stood before this edge, so a concurrent
    // config write never changes the verdict for the command in CHECK.
    storage_perm_check #(
        .ADDR_W  (ADDR_W),
        .REGIONS (REGIONS)
    ) u_perm_check (
        .perm  (perm_reg),
        .addr  (cmd_addr_reg),
        .write (cmd_write_reg),
        .priv  (cmd_priv_reg),
        .allow (allow)
    );

    assign deny_err_next = cmd_write_reg ? ERR_WR_DENY : ERR_RD_DENY;

    // The write uses the old lock value, so a same-cycle write+lock still loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perm_reg <= '0;
            lock_reg <= 1'b0;
        end else begin
            if (cfg_we && !lock_reg) begin
                perm_reg <= cfg_perm;
            end
            if (cfg_lock) begin
                lock_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= ERR_OK;
            mem_we_reg    <= 1'b0;
            mem_re_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cmd_write_reg <= 1'b0;
            cmd_priv_reg  <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
            wait_cnt_reg  <= '0;
        end else begin
            mem_we_reg <= 1'b0;
            mem_re_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        cmd_write_reg <= req_write;
                        cmd_addr_reg  <= req_addr;
                        cmd_wdata_reg <= req_wdata;
                        cmd_priv_reg  <= req_priv;
                        req_ready_reg <= 1'b0;
                        state_reg     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (allow) begin
                        mem_addr_reg  <= cmd_addr_reg;
                        mem_wdata_reg <= cmd_wdata_reg;
                        mem_we_reg    <= cmd_write_reg;
                        mem_re_reg    <= !cmd_write_reg;
                        state_reg     <= ST_ISSUE;
                    end else begin
                        rsp_err_reg   <= deny_err_next;
                        rsp_rdata_reg <= '0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RESP;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_write_reg) begin
                        rsp_err_reg   <= ERR_OK;
                        rsp_rdata_reg <= '0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RESP;
                    end else begin
                        wait_cnt_reg  <= CNT_W'(RD_LAT - 1);
                        state_reg     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == '0) begin
                        rsp_rdata_reg <= mem_rdata;
                        rsp_err_reg   <= ERR_OK;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RESP;
                    end else begin
                        wait_cnt_reg  <= wait_cnt_reg - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ACCESS_LOG_EN
    logic [15:0]       deny_cnt_reg;
    logic [ADDR_W-1:0] last_deny_addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deny_cnt_reg       <= '0;
            last_deny_addr_reg <= '0;
        end else if (state_reg == ST_CHECK && !allow) begin
            if (deny_cnt_reg != 16'hFFFF) begin
                deny_cnt_reg <= deny_cnt_reg + 16'd1;
            end
            last_deny_addr_reg <= cmd_addr_reg;
        end
    end

    assign deny_cnt       = deny_cnt_reg;
    assign last_deny_addr = last_deny_addr_reg;
`endif

    assign req_ready   = req_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;
    assign perm_locked = lock_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign mem_we      = mem_we_reg;
    assign mem_re      = mem_re_reg;

endmodule

// File: tb/tb_storage_access_initiator.sv
// Bench for storage_access_initiator: directed vector table, hand sequences for
// config/reset corners, and random commands against a permission/memory model.
module tb_storage_access_initiator;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int REGIONS = 4;
    localparam int RD_LAT  = 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic                 req_write = 1'b0;
    logic [ADDR_W-1:0]    req_addr = '0;
    logic [DATA_W-1:0]    req_wdata = '0;
    logic                 req_priv = 1'b0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [DATA_W-1:0]    rsp_rdata;
    logic [1:0]           rsp_err;
    logic                 cfg_we = 1'b0;
    logic [2*REGIONS-1:0] cfg_perm = '0;
    logic                 cfg_lock = 1'b0;
    logic                 perm_locked;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic                 mem_we;
    logic                 mem_re;
    logic [DATA_W-1:0]    mem_rdata;
`ifdef ACCESS_LOG_EN
    logic [15:0]          deny_cnt;
    logic [ADDR_W-1:0]    last_deny_addr;
`endif

    storage_access_initiator #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .REGIONS (REGIONS),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_priv    (req_priv),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .cfg_we      (cfg_we),
        .cfg_perm    (cfg_perm),
        .cfg_lock    (cfg_lock),
        .perm_locked (perm_locked),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata)
`ifdef ACCESS_LOG_EN
        ,
        .deny_cnt       (deny_cnt),
        .last_deny_addr (last_deny_addr)
`endif
    );

    always #5 clk = ~clk;

    // Storage array: data appears RD_LAT cycles after mem_re, garbage otherwise.
    logic [DATA_W-1:0] stor [256];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (mem_we === 1'b1) stor[mem_addr] <= mem_wdata;
        rd_pipe[0] <= (mem_re === 1'b1) ? stor[mem_addr] : 32'hDEAD_0BAD;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    int cyc = 0;
    int we_cnt = 0, re_cnt = 0, last_we_cyc = -1, last_re_cyc = -1;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin we_cnt++; last_we_cyc = cyc; end
        if (mem_re === 1'b1) begin re_cnt++; last_re_cyc = cyc; end
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [256];
    logic [7:0]        perm_model = '0;
    bit                lock_model = 1'b0;
    int                deny_model = 0;
    logic [7:0]        last_deny_model = '0;

    int checks = 0, errors = 0;
    int t0, we0, re0;
    bit cur_w, cur_p;
    logic [7:0]  cur_a;
    logic [31:0] cur_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_allow(input bit w, input logic [7:0] a, input bit p);
        int region = int'(a) / (256 / REGIONS);
        return p || perm_model[2*region + int'(w)];
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; rsp_ready = 1'b0; cfg_we = 1'b0; cfg_lock = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'd0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_re", 32'(mem_re), 32'd0);
        check("rst.mem_addr", 32'(mem_addr), 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        check("rst.perm_locked", 32'(perm_locked), 32'd0);
`ifdef ACCESS_LOG_EN
        check("rst.deny_cnt", 32'(deny_cnt), 32'd0);
        check("rst.last_deny_addr", 32'(last_deny_addr), 32'd0);
`endif
        perm_model = '0; lock_model = 1'b0; deny_model = 0; last_deny_model = '0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cfg_op(input bit we, input logic [7:0] perm, input bit lock);
        cfg_we = we; cfg_perm = perm; cfg_lock = lock;
        @(negedge clk);
        cfg_we = 1'b0; cfg_lock = 1'b0;
        if (we && !lock_model) perm_model = perm;
        if (lock) lock_model = 1'b1;
        check("cfg.perm_locked", 32'(perm_locked), 32'(lock_model));
        $display("cfg   we=%0d perm=%h lock=%0d -> model perm=%h locked=%0d", we, perm, lock, perm_model, lock_model);
    endtask

    // Handshakes one command; returns at the negedge of the CHECK cycle.
    task automatic start_cmd(input bit w, input logic [7:0] a, input logic [31:0] d, input bit p);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        cur_w = w; cur_a = a; cur_d = d; cur_p = p;
        we0 = we_cnt; re0 = re_cnt; t0 = cyc;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_priv = p;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 8'($urandom); req_wdata = $urandom; req_priv = 1'($urandom);
    endtask

    task automatic finish_cmd(input string name, input int hold, input logic [1:0] exp_err,
                              input logic [31:0] exp_rd, input int exp_lat, input int exp_we, input int exp_re);
        int n = 0;
        int lat;
        logic [31:0] rd0;
        logic [1:0]  e0;
        while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        lat = cyc - t0;
        check({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({name, ".latency"}, 32'(lat), 32'(exp_lat));
        check({name, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
        check({name, ".rsp_rdata"}, rsp_rdata, exp_rd);
        rd0 = rsp_rdata; e0 = rsp_err;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_write = 1'($urandom); req_addr = 8'($urandom);
            @(negedge clk);
            check({name, ".hold.rsp_valid"}, 32'(rsp_valid), 32'd1);
            check({name, ".hold.rsp_rdata"}, rsp_rdata, rd0);
            check({name, ".hold.rsp_err"}, 32'(rsp_err), 32'(e0));
            check({name, ".hold.req_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, ".post.rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, ".post.req_ready"}, 32'(req_ready), 32'd1);
        check({name, ".mem_we_count"}, 32'(we_cnt - we0), 32'(exp_we));
        check({name, ".mem_re_count"}, 32'(re_cnt - re0), 32'(exp_re));
        if (exp_we != 0) check({name, ".mem_we_cycle"}, 32'(last_we_cyc - t0), 32'd2);
        if (exp_re != 0) check({name, ".mem_re_cycle"}, 32'(last_re_cyc - t0), 32'd2);
        if (cur_w && exp_err == 2'b00) ref_mem[cur_a] = cur_d;
        if (exp_err != 2'b00) begin deny_model++; last_deny_model = cur_a; end
        $display("txn   %-16s w=%0d addr=%h wdata=%h priv=%0d hold=%0d -> err=%0d rdata=%h lat=%0d",
                 name, cur_w, cur_a, cur_d, cur_p, hold, rsp_err, rd0, lat);
    endtask

    // Model-driven command: expectations come from the permission/memory model.
    task automatic model_cmd(input string name, input bit w, input logic [7:0] a,
                             input logic [31:0] d, input bit p, input int hold);
        bit ok = model_allow(w, a, p);
        logic [1:0] e = ok ? 2'b00 : (w ? 2'b10 : 2'b01);
        logic [31:0] r = (ok && !w) ? ref_mem[a] : 32'd0;
        int lat = ok ? (w ? 3 : 3 + RD_LAT) : 2;
        start_cmd(w, a, d, p);
        finish_cmd(name, hold, e, r, lat, int'(ok && w), int'(ok && !w));
    endtask

    typedef struct {
        bit          cfg_we;
        logic [7:0]  cfg_perm;
        bit          cfg_lock;
        bit          w;
        logic [7:0]  addr;
        logic [31:0] wdata;
        bit          priv;
        int          hold;
        logic [1:0]  err;
        logic [31:0] rdata;
        int          lat;
        int          n_we;
        int          n_re;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];
    int   t0s  [NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            stor[i]    = 32'hA500_0000 | 32'(i);
            ref_mem[i] = 32'hA500_0000 | 32'(i);
        end
        rd_pipe[0] = '0;

        //        cfg_we perm  lock  w  addr   wdata          priv hold  err    rdata         lat        we re
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 32'h0,        1'b0, 0, 2'b01, 32'h0,        2,          0, 0};
        vecs[1]  = '{1'b1, 8'h0F, 1'b0, 1'b1, 8'h05, 32'h12345678, 1'b0, 0, 2'b00, 32'h0,        3,          1, 0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h05, 32'h0,        1'b0, 5, 2'b00, 32'h12345678, 3 + RD_LAT, 0, 1};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hC0, 32'hDEADBEEF, 1'b0, 0, 2'b10, 32'h0,        2,          0, 0};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hC0, 32'hDEADBEEF, 1'b1, 0, 2'b00, 32'h0,        3,          1, 0};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hC0, 32'h0,        1'b0, 0, 2'b01, 32'h0,        2,          0, 0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hC0, 32'h0,        1'b1, 2, 2'b00, 32'hDEADBEEF, 3 + RD_LAT, 0, 1};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h45, 32'h0,        1'b0, 0, 2'b00, 32'hA5000045, 3 + RD_LAT, 0, 1};
        vecs[8]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'h80, 32'hCAFEF00D, 1'b0, 0, 2'b10, 32'h0,        2,          0, 0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h80, 32'h0,        1'b0, 1, 2'b01, 32'h0,        2,          0, 0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h7F, 32'h0BADF00D, 1'b0, 0, 2'b00, 32'h0,        3,          1, 0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h7F, 32'h0,        1'b0, 0, 2'b00, 32'h0BADF00D, 3 + RD_LAT, 0, 1};

        apply_reset();

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].cfg_we || vecs[i].cfg_lock)
                cfg_op(vecs[i].cfg_we, vecs[i].cfg_perm, vecs[i].cfg_lock);
            start_cmd(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].priv);
            t0s[i] = t0;
            finish_cmd($sformatf("vec%0d", i), vecs[i].hold, vecs[i].err, vecs[i].rdata,
                       vecs[i].lat, vecs[i].n_we, vecs[i].n_re);
        end
        check("locked_after_table", 32'(perm_locked), 32'd1);
        check("write_throughput", 32'(t0s[11] - t0s[10]), 32'd4);

        // Reset clears the lock and permissions.
        apply_reset();
        model_cmd("after_rst_rd", 1'b0, 8'h05, 32'h0, 1'b0, 0);

        // Write and lock in the same cycle: permission loads, then lock engages.
        cfg_op(1'b1, 8'h30, 1'b1);
        model_cmd("wl_wr_r2", 1'b1, 8'h80, 32'h5555AAAA, 1'b0, 0);
        model_cmd("wl_rd_r2", 1'b0, 8'h80, 32'h0, 1'b0, 0);
        model_cmd("wl_rd_r0", 1'b0, 8'h10, 32'h0, 1'b0, 0);
        cfg_op(1'b1, 8'hFF, 1'b0);
        model_cmd("wl_rd_r0_b", 1'b0, 8'h10, 32'h0, 1'b0, 0);

        // A config write in the CHECK cycle does not affect that command.
        apply_reset();
        cfg_op(1'b1, 8'h0F, 1'b0);
        start_cmd(1'b0, 8'h05, 32'h0, 1'b0);
        cfg_we = 1'b1; cfg_perm = 8'h00;
        @(negedge clk);
        cfg_we = 1'b0;
        finish_cmd("cfg_in_check", 0, 2'b00, ref_mem[8'h05], 3 + RD_LAT, 0, 1);
        perm_model = 8'h00;
        model_cmd("cfg_after", 1'b0, 8'h05, 32'h0, 1'b0, 0);

        // Reset mid-transaction aborts the command with no response.
        cfg_op(1'b1, 8'h0F, 1'b0);
        start_cmd(1'b0, 8'h05, 32'h0, 1'b0);
        @(negedge clk);
        begin
            int seen = 0;
            rst_n = 1'b0;
            @(negedge clk);
            check("midrst.perm_locked", 32'(perm_locked), 32'd0);
            check("midrst.mem_re", 32'(mem_re), 32'd0);
            rst_n = 1'b1;
            perm_model = '0; lock_model = 1'b0; deny_model = 0; last_deny_model = '0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (rsp_valid === 1'b1) seen++;
            end
            check("midrst.no_response", 32'(seen), 32'd0);
            check("midrst.req_ready", 32'(req_ready), 32'd1);
            $display("txn   mid_reset        read 0x05 aborted, responses seen=%0d", seen);
        end
        model_cmd("midrst_after", 1'b0, 8'h05, 32'h0, 1'b0, 0);

        // Denied-access log sequence.
        apply_reset();
        model_cmd("log_rd_80", 1'b0, 8'h80, 32'h0, 1'b0, 0);
        model_cmd("log_wr_90", 1'b1, 8'h90, 32'h11112222, 1'b0, 0);
        model_cmd("log_rd_c4", 1'b0, 8'hC4, 32'h0, 1'b0, 0);
`ifdef ACCESS_LOG_EN
        check("log.deny_cnt", 32'(deny_cnt), 32'd3);
        check("log.last_deny_addr", 32'(last_deny_addr), 32'hC4);
`endif

        // Randomized commands against the model.
        apply_reset();
        cfg_op(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) cfg_op(1'b1, 8'($urandom), 1'b0);
            model_cmd($sformatf("rnd%0d", i), 1'($urandom), 8'($urandom), $urandom,
                      ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
        end
`ifdef ACCESS_LOG_EN
        check("rnd.deny_cnt", 32'(deny_cnt), 32'(deny_model));
        check("rnd.last_deny_addr", 32'(last_deny_addr), 32'(last_deny_model));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
